// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_pkg
//  Description : Shared widths and FSM state encodings for the MEM stage.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/data_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_array
//  Description : Single-port synchronous RAM, 2**ADDR_W x 32, registered read
//                returning the pre-write contents.
//  Revision    : 1.0  initial release
// ============================================================================
module data_mem_array
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_stage
//  Description : MEM pipeline stage with multi-cycle data memory access,
//                pipeline stall and MEM/WB register. Optional misaligned
//                access detection enabled by MEM_ALIGN_CHECK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MemRead_In,
    input  logic              MemWrite_In,
    input  logic              RegWrite_In,
    input  logic              MemToReg_In,
    input  logic [DATA_W-1:0] ALUResult_In,
    input  logic [DATA_W-1:0] WriteData_In,
    input  logic [REG_W-1:0]  WriteReg_In,
    output logic              Stall,
    output logic              RegWrite_Out,
    output logic              MemToReg_Out,
    output logic [DATA_W-1:0] ReadData_Out,
    output logic [DATA_W-1:0] ALUResult_Out,
    output logic [REG_W-1:0]  WriteReg_Out
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              AlignError
`endif
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               reg_write_q, reg_write_d;
    logic               mem_to_reg_q, mem_to_reg_d;
    logic [DATA_W-1:0]  read_data_q, read_data_d;
    logic [DATA_W-1:0]  alu_result_q, alu_result_d;
    logic [REG_W-1:0]   write_reg_q, write_reg_d;
    logic               align_error_q, align_error_d;

    logic               w_req;
    logic               w_done;
    logic               w_misaligned;
    logic               w_stall;
    logic               w_mem_we;
    logic [DATA_W-1:0]  w_mem_rdata;

    assign w_req  = MemRead_In | MemWrite_In;
    assign w_done = (state_q == ST_WAIT) && (cnt_q == '0);

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misaligned = w_req && (ALUResult_In[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    // Reset on the completion edge must also cancel the store.
    assign w_mem_we = w_done && MemWrite_In && !w_misaligned && !Reset;

    data_mem_array #(
        .ADDR_W (ADDR_W)
    ) u_data_mem_array (
        .clk   (Clk),
        .we    (w_mem_we),
        .addr  (ALUResult_In[ADDR_W+1:2]),
        .wdata (WriteData_In),
        .rdata (w_mem_rdata)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        w_stall       = 1'b0;
        reg_write_d   = RegWrite_In;
        mem_to_reg_d  = MemToReg_In;
        read_data_d   = '0;
        alu_result_d  = ALUResult_In;
        write_reg_d   = WriteReg_In;
        align_error_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_req) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    w_stall = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    w_stall = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    // The RAM has had at least one edge with a stable address.
                    if (MemRead_In && !MemWrite_In && !w_misaligned) begin
                        read_data_d = w_mem_rdata;
                    end
                    if (w_misaligned) begin
                        reg_write_d   = 1'b0;
                        align_error_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (w_stall) begin
            reg_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            reg_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            read_data_q   <= '0;
            alu_result_q  <= '0;
            write_reg_q   <= '0;
            align_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            reg_write_q   <= reg_write_d;
            mem_to_reg_q  <= mem_to_reg_d;
            read_data_q   <= read_data_d;
            alu_result_q  <= alu_result_d;
            write_reg_q   <= write_reg_d;
            align_error_q <= align_error_d;
        end
    end

    assign Stall         = w_stall;
    assign RegWrite_Out  = reg_write_q;
    assign MemToReg_Out  = mem_to_reg_q;
    assign ReadData_Out  = read_data_q;
    assign ALUResult_Out = alu_result_q;
    assign WriteReg_Out  = write_reg_q;

`ifdef MEM_ALIGN_CHECK_EN
    assign AlignError = align_error_q;
`else
    logic w_unused;
    assign w_unused = align_error_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_stage
//  Description : Directed self-checking bench for mem_access_stage
//                (ADDR_W=10, LATENCY=2).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access_stage;

    logic        Clk;
    logic        Reset;
    logic        MemRead_In;
    logic        MemWrite_In;
    logic        RegWrite_In;
    logic        MemToReg_In;
    logic [31:0] ALUResult_In;
    logic [31:0] WriteData_In;
    logic [4:0]  WriteReg_In;
    logic        Stall;
    logic        RegWrite_Out;
    logic        MemToReg_Out;
    logic [31:0] ReadData_Out;
    logic [31:0] ALUResult_Out;
    logic [4:0]  WriteReg_Out;
`ifdef MEM_ALIGN_CHECK_EN
    logic        AlignError;
`endif

    int n_vec;
    int n_err;

    mem_access_stage #(
        .ADDR_W  (10),
        .LATENCY (2)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .MemRead_In    (MemRead_In),
        .MemWrite_In   (MemWrite_In),
        .RegWrite_In   (RegWrite_In),
        .MemToReg_In   (MemToReg_In),
        .ALUResult_In  (ALUResult_In),
        .WriteData_In  (WriteData_In),
        .WriteReg_In   (WriteReg_In),
        .Stall         (Stall),
        .RegWrite_Out  (RegWrite_Out),
        .MemToReg_Out  (MemToReg_Out),
        .ReadData_Out  (ReadData_Out),
        .ALUResult_Out (ALUResult_Out),
        .WriteReg_Out  (WriteReg_Out)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .AlignError    (AlignError)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic rw, input logic m2r,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] wreg);
        MemRead_In   = rd;
        MemWrite_In  = wr;
        RegWrite_In  = rw;
        MemToReg_In  = m2r;
        ALUResult_In = addr;
        WriteData_In = wd;
        WriteReg_In  = wreg;
    endtask

    // Applies one instruction, counts stall cycles (bounded), and steps through
    // the completion edge so MEM/WB holds the result on return.
    task automatic run_op(input logic rd, input logic wr, input logic rw, input logic m2r,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] wreg,
                          output int stalls, output bit bubbles_ok);
        drive(rd, wr, rw, m2r, addr, wd, wreg);
        #1;
        stalls     = 0;
        bubbles_ok = 1'b1;
        while (Stall === 1'b1 && stalls < 10) begin
            tick();
            stalls++;
            if (RegWrite_Out !== 1'b0 || MemToReg_Out !== 1'b0) bubbles_ok = 1'b0;
        end
        tick();
    endtask

    task automatic test_reset;
        drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        n_vec++;
        if ({RegWrite_Out, MemToReg_Out, ReadData_Out, ALUResult_Out, WriteReg_Out, Stall} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got rw=%0b m2r=%0b rd=%h alu=%h wr=%0d stall=%0b, want all 0",
                     RegWrite_Out, MemToReg_Out, ReadData_Out, ALUResult_Out, WriteReg_Out, Stall);
        end
`ifdef MEM_ALIGN_CHECK_EN
        n_vec++;
        if (AlignError !== 1'b0) begin
            n_err++;
            $display("FAIL reset_align: got %0b want 0", AlignError);
        end
`endif
    endtask

    task automatic test_passthrough;
        int s;
        bit b;
        run_op(0, 0, 1, 0, 32'h0000_1234, 32'h0, 5'd5, s, b);
        n_vec++;
        if (s != 0 || RegWrite_Out !== 1'b1 || ALUResult_Out !== 32'h1234 || WriteReg_Out !== 5'd5
            || ReadData_Out !== 32'h0 || MemToReg_Out !== 1'b0) begin
            n_err++;
            $display("FAIL passthru_a: got stalls=%0d rw=%0b alu=%h wr=%0d rd=%h m2r=%0b, want 0 1 00001234 5 0 0",
                     s, RegWrite_Out, ALUResult_Out, WriteReg_Out, ReadData_Out, MemToReg_Out);
        end
        run_op(0, 0, 0, 1, 32'hFFFF_FFFF, 32'h0, 5'd31, s, b);
        n_vec++;
        if (s != 0 || RegWrite_Out !== 1'b0 || MemToReg_Out !== 1'b1 || ALUResult_Out !== 32'hFFFF_FFFF
            || WriteReg_Out !== 5'd31) begin
            n_err++;
            $display("FAIL passthru_b: got stalls=%0d rw=%0b m2r=%0b alu=%h wr=%0d, want 0 0 1 ffffffff 31",
                     s, RegWrite_Out, MemToReg_Out, ALUResult_Out, WriteReg_Out);
        end
    endtask

    task automatic test_store_load;
        int s;
        bit b;
        run_op(0, 1, 0, 0, 32'h10, 32'hDEAD_BEEF, 5'd0, s, b);
        n_vec++;
        if (s != 2 || RegWrite_Out !== 1'b0 || ReadData_Out !== 32'h0) begin
            n_err++;
            $display("FAIL store_10: got stalls=%0d rw=%0b rd=%h, want 2 0 0", s, RegWrite_Out, ReadData_Out);
        end
        run_op(1, 0, 1, 1, 32'h10, 32'h0, 5'd9, s, b);
        n_vec++;
        if (s != 2 || ReadData_Out !== 32'hDEAD_BEEF || MemToReg_Out !== 1'b1 || WriteReg_Out !== 5'd9) begin
            n_err++;
            $display("FAIL load_10: got stalls=%0d rd=%h m2r=%0b wr=%0d, want 2 deadbeef 1 9",
                     s, ReadData_Out, MemToReg_Out, WriteReg_Out);
        end
        n_vec++;
        if (!b || RegWrite_Out !== 1'b1) begin
            n_err++;
            $display("FAIL load_bubbles: got bubbles_ok=%0b rw_at_done=%0b, want 1 1", b, RegWrite_Out);
        end
    endtask

    task automatic test_both_flags;
        int s;
        bit b;
        run_op(1, 1, 1, 1, 32'h30, 32'h1234_5678, 5'd3, s, b);
        n_vec++;
        if (s != 2 || ReadData_Out !== 32'h0) begin
            n_err++;
            $display("FAIL both_flags: got stalls=%0d rd=%h, want 2 0", s, ReadData_Out);
        end
        run_op(1, 0, 1, 1, 32'h30, 32'h0, 5'd3, s, b);
        n_vec++;
        if (ReadData_Out !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL both_readback: got %h want 12345678", ReadData_Out);
        end
    endtask

    task automatic test_reset_abort;
        int s;
        bit b;
        drive(0, 1, 0, 0, 32'h20, 32'h55, 5'd0);
        #1;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        #1;
        n_vec++;
        if (Stall !== 1'b0 || RegWrite_Out !== 1'b0) begin
            n_err++;
            $display("FAIL abort_state: got stall=%0b rw=%0b, want 0 0", Stall, RegWrite_Out);
        end
        run_op(1, 0, 1, 1, 32'h20, 32'h0, 5'd1, s, b);
        n_vec++;
        if (s != 2 || ReadData_Out !== 32'h0) begin
            n_err++;
            $display("FAIL abort_store: got stalls=%0d rd=%h, want 2 0", s, ReadData_Out);
        end
    endtask

    task automatic test_align;
        int s;
        bit b;
        run_op(0, 1, 1, 0, 32'h22, 32'hA5A5_A5A5, 5'd4, s, b);
        n_vec++;
        if (s != 2) begin
            n_err++;
            $display("FAIL align_timing: got stalls=%0d want 2", s);
        end
`ifdef MEM_ALIGN_CHECK_EN
        n_vec++;
        if (AlignError !== 1'b1 || RegWrite_Out !== 1'b0) begin
            n_err++;
            $display("FAIL align_flag: got ae=%0b rw=%0b, want 1 0", AlignError, RegWrite_Out);
        end
        run_op(1, 0, 1, 1, 32'h20, 32'h0, 5'd4, s, b);
        n_vec++;
        if (ReadData_Out !== 32'h0 || AlignError !== 1'b0) begin
            n_err++;
            $display("FAIL align_suppressed: got rd=%h ae=%0b, want 0 0", ReadData_Out, AlignError);
        end
`else
        run_op(1, 0, 1, 1, 32'h20, 32'h0, 5'd4, s, b);
        n_vec++;
        if (ReadData_Out !== 32'hA5A5_A5A5) begin
            n_err++;
            $display("FAIL unaligned_word: got %h want a5a5a5a5", ReadData_Out);
        end
`endif
    endtask

    task automatic test_wrap;
        int s;
        bit b;
        run_op(0, 1, 0, 0, 32'h1000, 32'h77, 5'd0, s, b);
        run_op(1, 0, 1, 1, 32'h0, 32'h0, 5'd7, s, b);
        n_vec++;
        if (ReadData_Out !== 32'h77 || RegWrite_Out !== 1'b1) begin
            n_err++;
            $display("FAIL addr_wrap: got rd=%h rw=%0b, want 00000077 1", ReadData_Out, RegWrite_Out);
        end
    endtask

    task automatic test_back_to_back;
        int s;
        bit b;
        run_op(0, 1, 0, 0, 32'h44, 32'hCAFE_0001, 5'd0, s, b);
        run_op(0, 1, 0, 0, 32'h48, 32'hCAFE_0002, 5'd0, s, b);
        run_op(1, 0, 1, 1, 32'h44, 32'h0, 5'd10, s, b);
        n_vec++;
        if (s != 2 || ReadData_Out !== 32'hCAFE_0001) begin
            n_err++;
            $display("FAIL b2b_load44: got stalls=%0d rd=%h, want 2 cafe0001", s, ReadData_Out);
        end
        run_op(1, 0, 1, 1, 32'h48, 32'h0, 5'd11, s, b);
        n_vec++;
        if (ReadData_Out !== 32'hCAFE_0002 || WriteReg_Out !== 5'd11) begin
            n_err++;
            $display("FAIL b2b_load48: got rd=%h wr=%0d, want cafe0002 11", ReadData_Out, WriteReg_Out);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        Reset = 1'b1;
        drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        test_reset();
        test_passthrough();
        test_store_load();
        test_both_flags();
        test_reset_abort();
        test_align();
        test_wrap();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
